// File: rtl/fc_layer_sequencer.sv
// Fully-connected output stage sequencer: captures a pixel vector, then walks the
// weight memory one neuron at a time and streams each neuron result with its index.
module fc_layer_sequencer #(
  parameter int NUM_NEURONS = 10,
  parameter int IDX_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [63:0]      pix_in,
  output logic             busy,
  output logic             done,
  output logic             w_rd_en,
  output logic [IDX_W-1:0] w_addr,
  input  logic [63:0]      w_rdata,
  output logic [63:0]      nrn_pixels,
  output logic [63:0]      nrn_weight,
  input  logic [7:0]       nrn_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [IDX_W-1:0] out_index
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_CAPT  = 3'd3;
  localparam logic [2:0] S_EMIT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NEURONS - 1);

  logic [2:0]       state;
  logic [IDX_W-1:0] idx;
  logic [63:0]      pix_q;
  logic [63:0]      wgt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      pix_q     <= '0;
      wgt_q     <= '0;
      out_data  <= '0;
      out_index <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          pix_q <= pix_in;
          idx   <= '0;
          state <= S_FETCH;
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          wgt_q <= w_rdata;
          state <= S_CAPT;
        end
        S_CAPT: begin
          out_data  <= nrn_result;
          out_index <= idx;
          state     <= S_EMIT;
        end
        S_EMIT: if (out_ready) begin
          if (idx == LAST) begin
            state <= S_DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_FETCH;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // The weight is passed straight through during LOAD so the neuron's registered
  // result is already valid in CAPT; the register keeps it steady afterwards.
  assign nrn_weight = (state == S_LOAD) ? w_rdata : wgt_q;
  assign nrn_pixels = pix_q;

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign w_rd_en   = (state == S_FETCH);
  assign w_addr    = idx;
  assign out_valid = (state == S_EMIT);

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Directed bench for fc_layer_sequencer with a registered weight memory and neuron model.
module tb_fc_layer_sequencer;

  logic        clk, rst;
  logic        start, out_ready;
  logic [63:0] pix_in;
  logic        busy, done, w_rd_en, out_valid;
  logic [3:0]  w_addr, out_index;
  logic [63:0] w_rdata, nrn_pixels, nrn_weight;
  logic [7:0]  nrn_result, out_data;

  logic        start1;
  logic        busy1, done1, w_rd_en1, out_valid1;
  logic [3:0]  w_addr1, out_index1;
  logic [63:0] w_rdata1, nrn_pixels1, nrn_weight1;
  logic [7:0]  nrn_result1, out_data1;

  logic [63:0] wmem [16];
  logic [7:0]  exp_data [10];
  logic [3:0]  rd_log [$];
  logic [3:0]  rd_log1 [$];
  int          done_cnt, done_cnt1;
  int          tests_run, fails;

  fc_layer_sequencer #(.NUM_NEURONS(10), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .pix_in(pix_in), .busy(busy), .done(done),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rdata(w_rdata), .nrn_pixels(nrn_pixels),
    .nrn_weight(nrn_weight), .nrn_result(nrn_result), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_index(out_index));

  fc_layer_sequencer #(.NUM_NEURONS(1), .IDX_W(4)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .pix_in(pix_in), .busy(busy1), .done(done1),
    .w_rd_en(w_rd_en1), .w_addr(w_addr1), .w_rdata(w_rdata1), .nrn_pixels(nrn_pixels1),
    .nrn_weight(nrn_weight1), .nrn_result(nrn_result1), .out_valid(out_valid1),
    .out_ready(1'b1), .out_data(out_data1), .out_index(out_index1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] dot(input logic [63:0] p, input logic [63:0] w);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) s = s + p[8*i +: 8] * w[8*i +: 8];
    return s;
  endfunction

  // External memory and neuron: one-cycle read latency, registered result.
  always @(posedge clk) begin
    if (w_rd_en)  w_rdata  <= wmem[w_addr];
    if (w_rd_en1) w_rdata1 <= wmem[w_addr1];
  end
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      nrn_result  <= '0;
      nrn_result1 <= '0;
    end else begin
      nrn_result  <= dot(nrn_pixels, nrn_weight);
      nrn_result1 <= dot(nrn_pixels1, nrn_weight1);
    end
  end
  always @(posedge clk) begin
    if (w_rd_en)  rd_log.push_back(w_addr);
    if (w_rd_en1) rd_log1.push_back(w_addr1);
    if (done)  done_cnt++;
    if (done1) done_cnt1++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_pass(input string name, input logic [63:0] pix, input int stall_idx,
                          input int stall_len, input bit inj, input logic [63:0] alt,
                          input int exp_len);
    int c, nres, stalled, first, dcyc, log0, d0;
    logic [7:0] hd;
    logic [3:0] hi;
    log0 = rd_log.size();
    d0 = done_cnt;
    pix_in = pix; start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    c = 1; nres = 0; stalled = 0; first = -1; dcyc = -1; hd = '0; hi = '0;
    while (dcyc < 0 && c < 300) begin
      start = inj && (c == 10);
      pix_in = inj ? alt : pix;
      out_ready = 1'b1;
      if (out_valid) begin
        if (first < 0) first = c;
        if (out_index == 4'(stall_idx) && stalled < stall_len) begin
          out_ready = 1'b0;
          tests_run++;
          if (w_rd_en !== 1'b0) begin
            fails++; $display("FAIL %s stall_rd: w_rd_en=%b want 0", name, w_rd_en);
          end
          if (stalled > 0) begin
            tests_run++;
            if (out_data !== hd || out_index !== hi) begin
              fails++;
              $display("FAIL %s stall_hold: data=%0d idx=%0d want %0d/%0d", name, out_data, out_index, hd, hi);
            end
          end
          hd = out_data; hi = out_index; stalled++;
        end else begin
          tests_run++;
          if (nres > 9 || out_index !== 4'(nres) || out_data !== exp_data[nres % 10]) begin
            fails++;
            $display("FAIL %s result%0d: idx=%0d data=%0d want idx=%0d data=%0d",
                     name, nres, out_index, out_data, nres, exp_data[nres % 10]);
          end
          nres++;
        end
      end
      if (done) begin
        dcyc = c;
        if (inj) start = 1'b1;
      end
      tick();
      c++;
    end
    start = 1'b0;
    tests_run++;
    if (dcyc < 0) begin
      fails++; $display("FAIL %s timeout: no done after %0d cycles, want done", name, c);
    end
    tests_run++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL %s idle_after: busy=%b valid=%b want 0/0", name, busy, out_valid);
    end
    tests_run++;
    if (first != 4) begin
      fails++; $display("FAIL %s latency: first valid cycle %0d want 4", name, first);
    end
    tests_run++;
    if (nres != 10) begin
      fails++; $display("FAIL %s count: %0d results want 10", name, nres);
    end
    tests_run++;
    if (dcyc != exp_len) begin
      fails++; $display("FAIL %s length: done at cycle %0d want %0d", name, dcyc, exp_len);
    end
    tests_run++;
    if (done_cnt - d0 != 1) begin
      fails++; $display("FAIL %s done_pulses: %0d want 1", name, done_cnt - d0);
    end
    tests_run++;
    if (rd_log.size() - log0 != 10) begin
      fails++; $display("FAIL %s reads: %0d want 10", name, rd_log.size() - log0);
    end else begin
      for (int k = 0; k < 10; k++) begin
        tests_run++;
        if (rd_log[log0 + k] !== 4'(k)) begin
          fails++; $display("FAIL %s addr%0d: %0d want %0d", name, k, rd_log[log0 + k], k);
        end
      end
    end
  endtask

  task automatic load_ramp(input logic [7:0] pix_mult);
    for (int k = 0; k < 16; k++) wmem[k] = {8{8'(k)}};
    for (int k = 0; k < 10; k++) exp_data[k] = 8'(8 * k * pix_mult);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    tests_run++;
    if ({busy, done, w_rd_en, w_addr, out_valid, out_data, out_index, nrn_pixels, nrn_weight} !== '0) begin
      fails++; $display("FAIL reset_vals: busy=%b done=%b rd=%b valid=%b data=%0d want all 0",
                        busy, done, w_rd_en, out_valid, out_data);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    load_ramp(8'd1);
    run_pass("basic", {8{8'd1}}, -1, 0, 1'b0, '0, 41);
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 10; k++) begin wmem[k] = {8{8'd16}}; exp_data[k] = 8'd0; end
    run_pass("ovf_zero", {8{8'd16}}, -1, 0, 1'b0, '0, 41);
    for (int k = 0; k < 10; k++) begin wmem[k] = 64'h2; exp_data[k] = 8'd254; end
    run_pass("ovf_254", 64'hFF, -1, 0, 1'b0, '0, 41);
  endtask

  task automatic test_backpressure();
    load_ramp(8'd1);
    run_pass("backpressure", {8{8'd1}}, 2, 5, 1'b0, '0, 46);
  endtask

  task automatic test_mid_reset();
    int c, log0;
    bit hit;
    load_ramp(8'd1);
    pix_in = {8{8'd1}}; start = 1'b1; out_ready = 1'b0;
    tick();
    start = 1'b0;
    hit = 1'b0; c = 0;
    while (!hit && c < 100) begin
      out_ready = !(out_valid && out_index == 4'd3);
      if (out_valid && out_index == 4'd3) hit = 1'b1;
      else begin tick(); c++; end
    end
    tests_run++;
    if (!hit || out_data !== 8'd24) begin
      fails++; $display("FAIL midrst_pre: reached=%b data=%0d want 1/24", hit, out_data);
    end
    log0 = rd_log.size();
    rst = 1'b1;
    #1;
    tests_run++;
    if ({busy, done, w_rd_en, w_addr, out_valid, out_data, out_index, nrn_pixels, nrn_weight} !== '0) begin
      fails++; $display("FAIL midrst_zero: busy=%b valid=%b data=%0d idx=%0d want all 0",
                        busy, out_valid, out_data, out_index);
    end
    tick(); tick(); tick();
    tests_run++;
    if (rd_log.size() != log0) begin
      fails++; $display("FAIL midrst_reads: %0d reads during reset want 0", rd_log.size() - log0);
    end
    rst = 1'b0; out_ready = 1'b1;
    tick();
    run_pass("after_reset", {8{8'd1}}, -1, 0, 1'b0, '0, 41);
  endtask

  task automatic test_ignored_start();
    load_ramp(8'd1);
    run_pass("ign_start", {8{8'd1}}, -1, 0, 1'b1, {8{8'd2}}, 41);
    load_ramp(8'd2);
    run_pass("new_pix", {8{8'd2}}, -1, 0, 1'b0, '0, 41);
  endtask

  task automatic test_single();
    int c, log0, d0, vcyc, dcyc;
    wmem[0] = {8{8'd7}};
    log0 = rd_log1.size(); d0 = done_cnt1;
    pix_in = {8{8'd1}}; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    vcyc = -1; dcyc = -1;
    for (c = 1; c < 20; c++) begin
      if (out_valid1) begin
        vcyc = c;
        tests_run++;
        if (out_index1 !== 4'd0 || out_data1 !== 8'd56) begin
          fails++; $display("FAIL single_result: idx=%0d data=%0d want 0/56", out_index1, out_data1);
        end
      end
      if (done1 && dcyc < 0) dcyc = c;
      tick();
    end
    tests_run++;
    if (vcyc != 4 || dcyc != 5) begin
      fails++; $display("FAIL single_timing: valid@%0d done@%0d want 4/5", vcyc, dcyc);
    end
    tests_run++;
    if (rd_log1.size() - log0 != 1 || done_cnt1 - d0 != 1 || busy1 !== 1'b0) begin
      fails++; $display("FAIL single_counts: reads=%0d dones=%0d busy=%b want 1/1/0",
                        rd_log1.size() - log0, done_cnt1 - d0, busy1);
    end else begin
      tests_run++;
      if (rd_log1[log0] !== 4'd0) begin
        fails++; $display("FAIL single_addr: %0d want 0", rd_log1[log0]);
      end
    end
  endtask

  initial begin
    tests_run = 0; fails = 0; done_cnt = 0; done_cnt1 = 0;
    start = 1'b0; start1 = 1'b0; out_ready = 1'b1; pix_in = '0; rst = 1'b1;
    for (int k = 0; k < 16; k++) wmem[k] = '0;
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_mid_reset();
    test_ignored_start();
    test_single();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
